memc_deskew: RTL
================

# memc_deskew

Output-side counterpart of the A-operand skew memory. The A side turns stored rows into a zero-padded rhombus wavefront for the systolic MAC array. This block does the reverse on the result side: it captures the skewed column outputs of the array and reassembles them into an aligned DIM×DIM result matrix. Software or the next stage then reads the matrix back row by row.

## Interface
Parameters:
- BITS_C, 16, signed width of each result element
- DIM, 8, array dimension (rows = columns = DIM); must be ≥2

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a capture; sampled in IDLE or DONE only
- en  in  1  capture advance; a cycle counts only when en=1
- Cin  in  signed [BITS_C-1:0] ×DIM  one element per array column, skewed
- Crow  in  $clog2(DIM)  row address for readback
- Cout  out  signed [BITS_C-1:0] ×DIM  registered row Crow of the result buffer
- busy  out  1  high in CAPTURE
- done  out  1  high in DONE; matrix complete and stable

## Operation
- Storage: buf[DIM][DIM] of signed BITS_C.
- Capture counter t: width $clog2(2*DIM-1), range 0..2*DIM-2.
- States:
  - IDLE --start--> CAPTURE. On entry, t=0 and all of buf is cleared to 0.
  - CAPTURE: on each cycle with en=1, for every column j, write buf[t-j][j] <= Cin[j] if 0 ≤ t-j ≤ DIM-1; otherwise discard (skew padding). Then t <= t+1.
  - CAPTURE: the en=1 cycle with t=2*DIM-2 performs its writes and transitions to DONE.
  - DONE --start--> CAPTURE, with the same clear and t=0.
  - No other transitions.
- en=0 in CAPTURE: no write; t and state hold (stall).
- start in CAPTURE: ignored, with no restart.
- start and en together in IDLE/DONE: the start takes effect. The en is not a capture cycle because the first capture cycle is the next one.
- Readback: Cout <= buf[Crow] every cycle regardless of state. During CAPTURE it may show partial data; only DONE guarantees a complete matrix.
- Crow is always in range for power-of-two DIM. For non-power-of-two DIM, Crow ≥ DIM gives Cout = 0.
- No arithmetic on data. Values are stored bit-exact with no saturation or extension.

## Timing
- Reset (rst=1 at a clk edge):
  - state=IDLE, t=0, buf all 0, Cout all 0, busy=0, done=0.
  - Reset mid-CAPTURE discards all partial data.
- busy rises the cycle after start is accepted. busy falls and done rises the cycle after the final (t=2*DIM-2) en cycle.
- done falls the cycle after start is accepted in DONE.
- Capture length: exactly 2*DIM-1 en-qualified cycles (15 for DIM=8), plus any stall cycles.
- Element (row r, col j) is expected on Cin[j] at en-cycle t=r+j. This matches the A-side skew, where row r of A enters r cycles late.
- Read latency: 1 cycle from Crow to Cout.
- A write and a read of the same row on the same edge returns the old contents. There is no bypass.

## Structure
- Shared package tpu_pkg holds:
  - DIM and BITS_C defaults, used together with the A/B-side widths
  - the capture state enum {IDLE, CAPTURE, DONE}
- One sub-module is natural: deskew_column, instantiated DIM times, one per column j.
  - Holds buf[*][j] and has a parameter COL=j.
  - Inputs: t, the write strobe, clear, and Cin[j].
  - Computes its own in-range test and row index t-COL.
- The top level holds the FSM, counter, and Cout register.

## Test plan
- Reset: drive rst=1 for 2 cycles mid-CAPTURE → busy=0, done=0, Cout all 0 for every Crow. A following start + 15 en cycles completes normally.
- Identity-pattern capture (DIM=8): drive Cin[j]=16*(t-j)+j when 0≤t-j≤7, else 0x7FFF garbage, for t=0..14 with en=1 → done rises after cycle 15. Crow=r gives Cout[j]=16*r+j for all r,j; no 0x7FFF appears.
- Stall: same stimulus with en=0 on every third cycle, and Cin changed to junk on the stalled cycles → result identical to the identity-pattern test; total 15 en cycles still required.
- start ignored: pulse start at t=5 in CAPTURE → capture continues to t=14. The result matches with no clear and no restart.
- Recapture: from DONE, start, then capture a pattern with all elements -1 → mid-capture reads of not-yet-written cells show 0 (cleared). The final matrix is all 0xFFFF; done toggles 1→0→1.
- Read latency: in DONE, step Crow 0..7 on consecutive cycles → Cout shows row k exactly one cycle after Crow=k.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default array geometry and the result-capture state encoding.
package tpu_pkg;

    localparam int DIM_DEF    = 8;
    localparam int BITS_C_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_e;

endpackage

// File: rtl/memc_deskew_column.sv
// One result column: undoes the skew of column COL by writing the element seen at
// capture step t into row t-COL, and drops the zero-padding steps outside the matrix.
module deskew_column #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8,
    parameter int COL    = 0,
    parameter int TW     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [TW-1:0]                  t,
    input  logic                           we,
    input  logic                           clr,
    input  logic signed [BITS_C-1:0]       din,
    output logic signed [DIM-1:0][BITS_C-1:0] cells
);

    localparam logic [TW-1:0] COL_T = TW'(COL);
    localparam logic [TW-1:0] DIM_T = TW'(DIM);

    logic [TW-1:0] row;
    logic          in_range;

    // Guard t>=COL first so the wrapped difference never aliases a real row.
    assign row      = t - COL_T;
    assign in_range = (t >= COL_T) && (row < DIM_T);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cells <= '0;
        end else if (we && in_range) begin
            for (int r = 0; r < DIM; r++) begin
                if (row == TW'(r)) cells[r] <= din;
            end
        end
    end

endmodule

// File: rtl/memc_deskew.sv
// Result-side deskew buffer: captures the skewed column outputs of the systolic array
// over 2*DIM-1 enabled cycles and presents the aligned matrix one row at a time.
module memc_deskew
    import tpu_pkg::*;
#(
    parameter int BITS_C = BITS_C_DEF,
    parameter int DIM    = DIM_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              en,
    input  logic signed [DIM-1:0][BITS_C-1:0] Cin,
    input  logic [$clog2(DIM)-1:0]            Crow,
    output logic signed [DIM-1:0][BITS_C-1:0] Cout,
    output logic                              busy,
    output logic                              done
);

    localparam int TW = $clog2(2*DIM-1);
    localparam int RW = $clog2(DIM);
    localparam logic [TW-1:0] T_LAST = TW'(2*DIM-2);

    cap_state_e    state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic          we, clr;

    logic signed [DIM-1:0][DIM-1:0][BITS_C-1:0] colbuf;   // [column][row]
    logic signed [DIM-1:0][BITS_C-1:0]          rowsel;

    for (genvar j = 0; j < DIM; j++) begin : g_col
        deskew_column #(
            .BITS_C (BITS_C),
            .DIM    (DIM),
            .COL    (j),
            .TW     (TW)
        ) u_col (
            .clk   (clk),
            .rst   (rst),
            .t     (t_q),
            .we    (we),
            .clr   (clr),
            .din   (Cin[j]),
            .cells (colbuf[j])
        );
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        we      = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CAPTURE;
                    t_d     = '0;
                    clr     = 1'b1;
                end
            end
            CAPTURE: begin
                if (en) begin
                    we = 1'b1;
                    if (t_q == T_LAST) begin
                        state_d = DONE;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row mux; an unmatched Crow (only possible for non-power-of-two DIM) reads zero.
    always_comb begin
        rowsel = '0;
        for (int r = 0; r < DIM; r++) begin
            if (Crow == RW'(r)) begin
                for (int j = 0; j < DIM; j++) rowsel[j] = colbuf[j][r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            Cout    <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            Cout    <= rowsel;
        end
    end

    assign busy = (state_q == CAPTURE);
    assign done = (state_q == DONE);

endmodule
